// File: rtl/seq_det_ctrl_if.sv
// Handshake bundle for seq_det_ctrl: the word stream into the controller
// and the per-frame result stream out of it. The master side is the
// producer of words / consumer of results; the slave side is the controller.
interface seq_det_ctrl_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;

    logic              res_valid;
    logic              res_ready;
    logic [CNT_W-1:0]  res_mealy;
    logic [CNT_W-1:0]  res_moore;
    logic              res_err;

    modport master (
        output in_valid, in_data, in_last, res_ready,
        input  in_ready, res_valid, res_mealy, res_moore, res_err
    );

    modport slave (
        input  in_valid, in_data, in_last, res_ready,
        output in_ready, res_valid, res_mealy, res_moore, res_err
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: frame controller for a Mealy/Moore sequence-detector pair.
// Accepts words, clears the detectors at frame start, serializes each word
// MSB-first onto det_din, counts hits with each detector's latency aligned
// and hands back one result per frame.
// Optional feature: define SEQ_DET_CTRL_SAT_EN to make the hit counters
// saturate at all-ones; otherwise they wrap.
module seq_det_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_det_ctrl_if.slave        bus,
    output logic                 det_rst,
    output logic                 det_din,
    input  logic                 det_mealy,
    input  logic                 det_moore
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        REPORT
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic              last_q;
    logic              first_q;
    logic [CNT_W-1:0]  mealy_cnt;
    logic [CNT_W-1:0]  moore_cnt;
    logic              err_q;
    logic              res_valid_q;
    logic              final_bit;

    // One-step counter update; saturating or wrapping depending on build.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef SEQ_DET_CTRL_SAT_EN
        return (&c) ? c : c + CNT_W'(1);
`else
        return c + CNT_W'(1);
`endif
    endfunction

    assign final_bit = (bit_idx == LAST_IDX);

    // Ready is combinational so it drops during reset yet is high in IDLE
    // on the very first cycle after reset releases.
    assign bus.in_ready = !rst && ((state == IDLE) ||
                                   ((state == SHIFT) && final_bit && !last_q));

    // Detectors are cleared whenever the controller is, and in CLR.
    assign det_rst = rst || (state == CLR);

    // Only SHIFT drives real data; CLR, DRAIN and idle states feed zeros.
    assign det_din = (state == SHIFT) && shreg[WORD_W-1];

    assign bus.res_valid = res_valid_q;
    assign bus.res_mealy = mealy_cnt;
    assign bus.res_moore = moore_cnt;
    assign bus.res_err   = err_q;

    // Frame FSM: load, clear, shift with hit counting, drain the Moore
    // pipeline stage, then hold the result until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_idx     <= '0;
            last_q      <= 1'b0;
            first_q     <= 1'b0;
            mealy_cnt   <= '0;
            moore_cnt   <= '0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg     <= bus.in_data;
                        last_q    <= bus.in_last;
                        mealy_cnt <= '0;
                        moore_cnt <= '0;
                        err_q     <= 1'b0;
                        state     <= CLR;
                    end
                end
                CLR: begin
                    bit_idx <= '0;
                    first_q <= 1'b1;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    first_q <= 1'b0;
                    if (det_mealy) begin
                        mealy_cnt <= bump(mealy_cnt);
                    end
                    // The Moore output lags one bit, so the first cycle of a
                    // frame still shows the response to pre-frame input.
                    if (det_moore && !first_q) begin
                        moore_cnt <= bump(moore_cnt);
                    end
                    if (final_bit) begin
                        bit_idx <= '0;
                        if (last_q) begin
                            state <= DRAIN;
                        end else if (bus.in_valid) begin
                            shreg  <= bus.in_data;
                            last_q <= bus.in_last;
                        end else begin
                            err_q <= 1'b1;
                            state <= DRAIN;
                        end
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                        shreg   <= {shreg[WORD_W-2:0], 1'b0};
                    end
                end
                DRAIN: begin
                    if (det_moore) begin
                        moore_cnt <= bump(moore_cnt);
                    end
                    res_valid_q <= 1'b1;
                    state       <= REPORT;
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
